// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the execute-stage multiply/divide control blocks.
// div_special resolves the RISC-V divide corner cases without using a divider.
package muldiv_pkg;

  localparam int DIV_XLEN = 32;
  localparam logic [DIV_XLEN-1:0] INT_MIN  = {1'b1, {(DIV_XLEN-1){1'b0}}};
  localparam logic [DIV_XLEN-1:0] ALL_ONES = {DIV_XLEN{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GUARD = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_DRAIN = 3'd5
  } div_state_t;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef struct packed {
    logic                hit;
    logic [DIV_XLEN-1:0] value;
  } div_special_t;

  // Divide-by-zero and signed overflow have architecturally fixed results.
  function automatic div_special_t div_special(input logic [DIV_XLEN-1:0] rs1,
                                               input logic [DIV_XLEN-1:0] rs2,
                                               input div_op_t             op);
    div_special_t res;
    res.hit   = 1'b0;
    res.value = '0;
    if (rs2 == '0) begin
      res.hit   = 1'b1;
      res.value = op[1] ? rs1 : ALL_ONES;
    end else if (!op[0] && (rs1 == INT_MIN) && (rs2 == ALL_ONES)) begin
      res.hit   = 1'b1;
      res.value = op[1] ? '0 : INT_MIN;
    end else begin
      res.hit   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// Execute-stage initiator for the divider start/status protocol: latches a
// divide request, issues it (or resolves it locally), stalls, and returns the result.
module div_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = DIV_XLEN,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [RD_W-1:0] req_rd,
  input  logic            flush,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic [RD_W-1:0] resp_rd,
  output logic            div_start,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  output logic            div_signed,
  input  logic            div_status,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder,
  input  logic            div_by_zero
);

  div_state_t      r_state;
  div_state_t      w_next_state;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic            r_is_rem;
  logic            r_signed;
  logic [RD_W-1:0] r_rd;
  logic [XLEN-1:0] r_result;
  logic            w_accept;
  logic            w_capture;
  logic            w_stall;
  div_special_t    w_special;
  logic            w_unused_dbz;

  // Zero divisors are resolved locally, so the divider's own flag carries no information.
  assign w_unused_dbz = div_by_zero;

  assign w_special    = div_special(req_rs1, req_rs2, div_op_t'(req_op));
  assign div_dividend = r_rs1;
  assign div_divisor  = r_rs2;
  assign div_signed   = r_signed;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand latch on accept; result from the special-case path or the divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_is_rem <= 1'b0;
      r_signed <= 1'b0;
      r_rd     <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_rs1    <= req_rs1;
      r_rs2    <= req_rs2;
      r_is_rem <= req_op[1];
      r_signed <= ~req_op[0];
      r_rd     <= req_rd;
      r_result <= w_special.value;
    end else if (w_capture) begin
      r_result <= r_is_rem ? div_remainder : div_quotient;
    end else begin
      r_result <= r_result;
    end
  end

  // Next-state decode and protocol outputs.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_stall      = 1'b0;
    resp_valid   = 1'b0;
    resp_data    = '0;
    resp_rd      = '0;
    div_start    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          w_accept     = 1'b1;
          w_stall      = 1'b1;
          w_next_state = w_special.hit ? ST_DONE : ST_ISSUE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_stall = 1'b1;
        if (flush) begin
          w_next_state = ST_IDLE;
        end else begin
          div_start    = 1'b1;
          w_next_state = ST_GUARD;
        end
      end
      // Divider status is not yet valid the cycle after start.
      ST_GUARD: begin
        w_stall      = 1'b1;
        w_next_state = flush ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        w_stall = 1'b1;
        if (flush) begin
          w_next_state = ST_DRAIN;
        end else if (!div_status) begin
          w_capture    = 1'b1;
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (!flush) begin
          resp_valid = 1'b1;
          resp_data  = r_result;
          resp_rd    = r_rd;
        end else begin
          resp_valid = 1'b0;
        end
        w_next_state = ST_IDLE;
      end
      // The divider cannot be aborted, so a killed op runs to completion here.
      ST_DRAIN: begin
        w_stall      = 1'b1;
        w_next_state = div_status ? ST_DRAIN : ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    stall = w_stall & reset;
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_signed;
  logic        div_status;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  // divider environment model
  int          lat_cfg = 1;
  int          busy_cnt;
  int          start_cnt;
  int          overlap_cnt;
  int          unstable_cnt;
  logic [31:0] m_a, m_b, m_q, m_r;
  logic        m_sgn;

  always #5 clk = ~clk;

  div_issue_ctrl #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush(flush),
    .stall(stall), .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_signed(div_signed), .div_status(div_status), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_by_zero(div_by_zero)
  );

  // Plain 64-bit arithmetic; returns {remainder, quotient} with RISC-V zero-divisor rules.
  function automatic logic [63:0] div_calc(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    if (y == 0) begin
      q = -1;
      r = x;
    end else begin
      q = x / y;
      r = x % y;
    end
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] qr;
    qr = div_calc(~op[0], a, b);
    return op[1] ? qr[63:32] : qr[31:0];
  endfunction

  function automatic logic ref_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  assign div_status    = (busy_cnt != 0);
  assign div_quotient  = div_status ? 32'hDEAD_BEEF : m_q;
  assign div_remainder = div_status ? 32'hBAAD_F00D : m_r;
  assign div_by_zero   = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cnt <= 0;
      m_q      <= 32'd0;
      m_r      <= 32'd0;
    end else if (div_start) begin
      start_cnt <= start_cnt + 1;
      if (busy_cnt != 0) overlap_cnt <= overlap_cnt + 1;
      m_a      <= div_dividend;
      m_b      <= div_divisor;
      m_sgn    <= div_signed;
      {m_r, m_q} <= div_calc(div_signed, div_dividend, div_divisor);
      busy_cnt <= lat_cfg;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (div_dividend !== m_a || div_divisor !== m_b || div_signed !== m_sgn)
        unstable_cnt <= unstable_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int lat, input string tag);
    int cyc;
    int s0;
    logic sp;
    @(negedge clk);
    lat_cfg   = lat;
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_rd    = rd;
    s0        = start_cnt;
    sp        = ref_special(op, a, b);
    #1;
    chk({tag, "_req_stall"}, {31'd0, stall}, 32'd1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!resp_valid && cyc < 60);
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_data"}, resp_data, ref_result(op, a, b));
    chk({tag, "_rd"}, {27'd0, resp_rd}, {27'd0, rd});
    chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_latency"}, cyc, sp ? 32'd1 : 32'(lat + 3));
    chk({tag, "_starts"}, start_cnt - s0, sp ? 32'd0 : 32'd1);
  endtask

  initial begin
    int cyc;
    int s0;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    start_cnt = 0; overlap_cnt = 0; unstable_cnt = 0;
    reset = 1'b0; flush = 1'b0;
    req_valid = 1'b1; req_op = 2'b00; req_rs1 = 32'd100; req_rs2 = 32'd7; req_rd = 5'd9;
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_div_start", {31'd0, div_start}, 32'd0);
    chk("rst_div_signed", {31'd0, div_signed}, 32'd0);
    chk("rst_dividend", div_dividend, 32'd0);
    reset = 1'b1;
    req_valid = 1'b0;

    do_op(2'b00, 32'd100, 32'd7, 5'd9, 2, "div_100_7");
    idle();
    do_op(2'b00, -32'sd100, 32'd7, 5'd1, 4, "div_m100_7");
    idle();
    do_op(2'b10, -32'sd100, 32'd7, 5'd2, 1, "rem_m100_7");
    idle();
    do_op(2'b01, 32'hFFFF_FF9C, 32'd7, 5'd3, 3, "divu_big_7");
    idle();
    do_op(2'b11, 32'hFFFF_FF9C, 32'd7, 5'd4, 2, "remu_big_7");
    idle();
    do_op(2'b00, 32'd55, 32'd0, 5'd5, 2, "div_by_zero");
    idle();
    do_op(2'b10, 32'd55, 32'd0, 5'd6, 2, "rem_by_zero");
    idle();
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 2, "div_ovf");
    idle();
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 2, "rem_ovf");
    idle();
    do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 3, "divu_ovf_ops");
    idle();

    // flush in the second WAIT cycle of a 6-cycle divide
    @(negedge clk);
    lat_cfg = 6; req_valid = 1'b1; req_op = 2'b00; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_rd = 5'd11;
    s0 = start_cnt;
    repeat (4) @(negedge clk);
    chk("flush_pre_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    cyc = 0;
    while (div_status && cyc < 20) begin
      chk("flush_drain_stall", {31'd0, stall}, 32'd1);
      chk("flush_drain_resp", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      cyc++;
    end
    chk("flush_status_fell", {31'd0, div_status}, 32'd0);
    chk("flush_last_drain_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    chk("flush_idle_stall", {31'd0, stall}, 32'd0);
    chk("flush_idle_resp", {31'd0, resp_valid}, 32'd0);
    chk("flush_starts", start_cnt - s0, 32'd1);
    do_op(2'b10, 32'd1000, 32'd3, 5'd12, 2, "rem_after_flush");

    // back-to-back with req_valid held
    do_op(2'b00, 32'd20, 32'd4, 5'd13, 1, "b2b_20_4");
    do_op(2'b00, 32'd9, 32'd3, 5'd14, 2, "b2b_9_3");
    do_op(2'b00, -32'sd8, 32'd2, 5'd15, 1, "b2b_m8_2");
    idle();

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: rb = rb;
      endcase
      do_op(rop, ra, rb, 5'($urandom_range(0, 31)), int'($urandom_range(1, 5)), "rand");
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    chk("no_start_overlap", overlap_cnt, 32'd0);
    chk("operands_stable", unstable_cnt, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
